// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared widths, command layout and FSM encoding for spi_reg_bridge
package spi_bridge_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CMD_RD_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD      = 3'd5
  } bridge_state_e;

  // Bit 7 of the command byte selects a read frame.
  function automatic logic is_read_cmd(input logic [DATA_W-1:0] cmd);
    return cmd[CMD_RD_BIT];
  endfunction

endpackage

// File: rtl/spi_bridge_addr_cnt.sv
// rtl/spi_bridge_addr_cnt.sv - register address counter; SPI_BRIDGE_AUTOINC_EN enables burst increment
module spi_bridge_addr_cnt
  import spi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

`ifdef SPI_BRIDGE_AUTOINC_EN
  // Load from the command byte wins; otherwise step by one, wrapping 7'h7F -> 7'h00.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_addr;
    end else if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end
`else
  // FIFO-port style: the address stays at the command address for the whole frame.
  logic unused_advance;
  assign unused_advance = advance;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_addr;
    end
  end
`endif

  // Address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register-file bridge; SPI_BRIDGE_AUTOINC_EN selects burst addressing
module spi_reg_bridge
  import spi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_load,
  output logic              overrun
);

  bridge_state_e     state_d, state_q;
  logic              frame_prev_d, frame_prev_q;
  logic              wr_en_d, wr_en_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] tx_byte_d, tx_byte_q;
  logic              overrun_d, overrun_q;
  logic              addr_load;
  logic              addr_advance;
  logic              rd_en_c;
  logic              tx_load_c;
  logic              frame_rise;

  // frame_prev_q resets high so a frame already active during rst is not taken
  // as a new frame; the bridge waits for SSEL to drop and rise again.
  assign frame_rise = frame_active & ~frame_prev_q;

  // Next-state and strobe decode; a low frame_active aborts whatever is in flight.
  always_comb begin
    state_d      = state_q;
    frame_prev_d = frame_active;
    wr_en_d      = 1'b0;
    wdata_d      = wdata_q;
    tx_byte_d    = tx_byte_q;
    overrun_d    = overrun_q;
    addr_load    = 1'b0;
    addr_advance = wr_en_q;
    rd_en_c      = 1'b0;
    tx_load_c    = 1'b0;
    if (!frame_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_rise) begin
            state_d   = ST_CMD;
            overrun_d = 1'b0;
          end
        end
        ST_CMD: begin
          if (byte_valid) begin
            addr_load = 1'b1;
            state_d   = is_read_cmd(byte_data) ? ST_RD_REQ : ST_WR;
          end
        end
        ST_WR: begin
          if (byte_valid) begin
            wr_en_d = 1'b1;
            wdata_d = byte_data;
          end
        end
        ST_RD_REQ: begin
          rd_en_c = 1'b1;
          state_d = ST_RD_WAIT;
          if (byte_valid) overrun_d = 1'b1;
        end
        ST_RD_WAIT: begin
          tx_load_c    = 1'b1;
          tx_byte_d    = reg_rdata;
          addr_advance = 1'b1;
          state_d      = ST_RD;
          if (byte_valid) overrun_d = 1'b1;
        end
        ST_RD: begin
          if (byte_valid) state_d = ST_RD_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_prev_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      tx_byte_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_prev_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      tx_byte_q    <= tx_byte_d;
      overrun_q    <= overrun_d;
    end
  end

  spi_bridge_addr_cnt u_addr_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (addr_load),
    .load_addr (byte_data[ADDR_W-1:0]),
    .advance   (addr_advance),
    .addr      (reg_addr)
  );

  // Read strobe and MISO byte come straight from the state so the fetched data
  // reaches the transmitter in the same cycle reg_rdata is valid.
  assign reg_rd_en = rd_en_c;
  assign tx_load   = tx_load_c;
  assign tx_byte   = tx_byte_d;
  assign reg_wr_en = wr_en_q;
  assign reg_wdata = wdata_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam logic [6:0] INC = 7'd1;
`else
  localparam logic [6:0] INC = 7'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_active;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_n;

  logic [7:0] mem [128];

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t tx_q[$];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] a0;
    logic [6:0] a1;
  } wvec_t;

  wvec_t wv [4];

  spi_reg_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .reg_addr     (reg_addr),
    .reg_wr_en    (reg_wr_en),
    .reg_wdata    (reg_wdata),
    .reg_rd_en    (reg_rd_en),
    .reg_rdata    (reg_rdata),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: read data valid the cycle after reg_rd_en.
  always @(posedge clk) if (reg_rd_en) reg_rdata <= mem[reg_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reg_wr_en || reg_rd_en) chk("wr_rd_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
    if (reg_wr_en) begin
      chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(reg_addr), 32'(e.addr));
        chk("wr_data", 32'(reg_wdata), 32'(e.data));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (reg_rd_en) begin
      chk("rd_pending", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        chk("rd_addr", 32'(reg_addr), 32'(e.addr));
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (tx_load) begin
      chk("tx_pending", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) begin
        e = tx_q.pop_front();
        chk("tx_byte", 32'(tx_byte), 32'(e.data));
        chk("tx_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_wr(input logic [6:0] a, input logic [7:0] d, input int c);
    wr_q.push_back('{addr: a, data: d, cyc: c});
  endtask

  task automatic push_rd(input logic [6:0] a, input int c);
    rd_q.push_back('{addr: a, data: 8'h00, cyc: c});
    tx_q.push_back('{addr: a, data: mem[a], cyc: c + 1});
  endtask

  task automatic frame_on();
    @(posedge clk); #1;
    frame_active = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame_off();
    @(posedge clk); #1;
    frame_active = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_byte(input logic [7:0] b);
    @(posedge clk); #1;
    byte_data  = b;
    byte_valid = 1'b1;
    last_n     = cyc;
  endtask

  task automatic end_byte();
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (16) @(posedge clk);
  endtask

  initial begin
    logic [7:0] exp_tx;
    wv[0] = '{8'h05, 8'hA5, 8'h3C, 7'h05, (INC != 0) ? 7'h06 : 7'h05};
    wv[1] = '{8'h7F, 8'h01, 8'h02, 7'h7F, (INC != 0) ? 7'h00 : 7'h7F};
    wv[2] = '{8'h40, 8'hFF, 8'h00, 7'h40, (INC != 0) ? 7'h41 : 7'h40};
    wv[3] = '{8'h2A, 8'h5A, 8'hC3, 7'h2A, (INC != 0) ? 7'h2B : 7'h2A};
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 5 + 3);
    mem[7'h10] = 8'h11;
    mem[7'h11] = 8'h22;
    mem[7'h12] = 8'h33;

    rst = 1'b1; frame_active = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Write frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      frame_on();
      start_byte(wv[i].cmd); end_byte();
      start_byte(wv[i].d0); push_wr(wv[i].a0, wv[i].d0, last_n + 1); end_byte();
      start_byte(wv[i].d1); push_wr(wv[i].a1, wv[i].d1, last_n + 1); end_byte();
      frame_off();
    end

    // Read frame with two dummy slots.
    frame_on();
    start_byte(8'h90); push_rd(7'h10, last_n + 1); end_byte();
    start_byte(8'h00); push_rd(7'h10 + INC, last_n + 1); end_byte();
    start_byte(8'h00); push_rd(7'h10 + INC + INC, last_n + 1); end_byte();
    frame_off();
    exp_tx = mem[7'h10 + INC + INC];
    @(negedge clk);
    chk("tx_hold_between_frames", 32'(tx_byte), 32'(exp_tx));

    // Byte arriving one cycle after a read command.
    frame_on();
    start_byte(8'h83); push_rd(7'h03, last_n + 1);
    @(posedge clk); #1;
    byte_data = 8'hEE;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    frame_off();
    @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    frame_on();
    @(negedge clk);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    frame_off();

    // frame_active drops while in RD_REQ: no read strobe, next byte is a command.
    frame_on();
    start_byte(8'h85);
    @(posedge clk); #1;
    byte_valid   = 1'b0;
    frame_active = 1'b0;
    repeat (3) @(posedge clk);
    frame_on();
    start_byte(8'h06); end_byte();
    start_byte(8'h5A); push_wr(7'h06, 8'h5A, last_n + 1); end_byte();
    frame_off();

    // rst in the middle of a write burst.
    frame_on();
    start_byte(8'h20); end_byte();
    start_byte(8'h77); push_wr(7'h20, 8'h77, last_n + 1); end_byte();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_addr", 32'(reg_addr), 32'd0);
    chk("midrst_wdata", 32'(reg_wdata), 32'd0);
    chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
    chk("midrst_wr_en", 32'(reg_wr_en), 32'd0);
    start_byte(8'h99); end_byte();
    frame_off();
    frame_on();
    start_byte(8'h30); end_byte();
    start_byte(8'h44); push_wr(7'h30, 8'h44, last_n + 1); end_byte();
    frame_off();

    repeat (5) @(posedge clk);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Consumes the byte stream of the SPI slave receiver (one-cycle byte-valid strobe plus frame-active level) and turns each SSEL frame into register-file accesses. The first byte of a frame is a command (R/W bit + 7-bit address); following bytes are write data or read slots. Provides the next MISO byte back to the SPI slave transmitter. Sits between the SPI slave and the board register file.

## Interface
- ADDR_W, 7: register address width; fixed by the command format.
- DATA_W, 8: data width; equals SPI byte width.

- clk  in  1  system clock; the only clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- frame_active  in  1  SSEL active, already synchronised by the SPI slave.
- byte_valid  in  1  one-cycle strobe: byte_data holds a complete received byte.
- byte_data  in  8  received byte, MSB first as shifted.
- reg_addr  out  7  register address; reset 0.
- reg_wr_en  out  1  one-cycle write strobe; reset 0.
- reg_wdata  out  8  write data; reset 0.
- reg_rd_en  out  1  one-cycle read strobe; reset 0.
- reg_rdata  in  8  read data, valid the cycle after reg_rd_en.
- tx_byte  out  8  next byte to shift out on MISO; reset 8'h00.
- tx_load  out  1  one-cycle strobe: tx_byte updated; reset 0.
- overrun  out  1  sticky: byte arrived while a read was outstanding; cleared at frame start; reset 0.

## Operation
- Command byte: bit 7 = 1 read, 0 write; bits 6:0 = start address.
- States: IDLE, CMD, WR, RD_REQ, RD_WAIT, RD.
- IDLE -> CMD when frame_active rises.
- CMD on byte_valid: latch address; bit7=0 -> WR; bit7=1 -> RD_REQ.
- WR on byte_valid: reg_wdata <= byte_data, reg_wr_en pulse at current address, then address advances (see Configuration). Stay in WR.
- RD_REQ: reg_rd_en pulse at current address -> RD_WAIT.
- RD_WAIT: capture reg_rdata into tx_byte, tx_load pulse, address advances -> RD.
- RD on byte_valid (master clocking out the slot): -> RD_REQ (prefetch next byte).
- byte_valid in RD_REQ or RD_WAIT: ignored, overrun set.
- frame_active low in any state: -> IDLE next cycle, outstanding strobes not issued; byte_valid in that same cycle is ignored.
- Address arithmetic: 7-bit, wraps 7'h7F -> 7'h00.
- tx_byte holds its last value between frames; cleared only by rst.

## Timing
- Write: byte_valid at cycle N -> reg_wr_en, reg_addr, reg_wdata valid at N+1.
- Read after command: byte_valid at N -> reg_rd_en at N+1 -> tx_load/tx_byte at N+2.
- Prefetch: byte_valid in RD at N -> reg_rd_en N+1, tx_load N+2. SPI byte period ≥ 16 clk guarantees no overrun.
- Strobes never exceed one cycle; reg_wr_en and reg_rd_en never assert together.
- rst mid-frame: all outputs to reset values next edge, state IDLE; bridge waits for frame_active to fall and rise again before accepting a command.

## Configuration
- SPI_BRIDGE_AUTOINC_EN defined: address increments after every write and every read fetch (burst access).
- Not defined: address stays at command address for the whole frame; repeated bytes hit the same register (FIFO-port style).

## Structure
- Package spi_bridge_pkg: state encoding, CMD_RD_BIT = 7, ADDR_W, DATA_W.
- One sub-module natural: spi_bridge_addr_cnt (load, advance, wrap, macro-gated increment).

## Test plan
- Frame: 8'h05, 8'hA5, 8'h3C -> reg_wr_en at addr 5 data A5, addr 6 data 3C (AUTOINC) / addr 5 both (no AUTOINC).
- Frame: 8'h90, then two dummy bytes, regfile returns 11/22 -> reg_rd_en at addr 10, 11, 12; tx_byte 11 then 22, each with tx_load at N+2.
- Write burst from 8'h7F with two data bytes -> second write at addr 00 (wrap).
- Read command followed by byte_valid 1 cycle after -> byte ignored, overrun = 1; new frame clears it.
- frame_active drops in RD_REQ -> no reg_rd_en, state IDLE, next frame's first byte decoded as command.
- rst asserted mid-write burst -> all outputs reset next cycle, no further reg_wr_en until a new frame.
